reg_bank_arbiter: RTL and testbench

- Shares one bank of DEPTH x WIDTH master-slave flip-flop registers between two write requesters.
- Arbitrates round-robin and sequences each write as setup -> enable strobe -> hold, so the register D inputs are stable around the enable pulse.
- Sits between the two requesting blocks and the register bank. Drives the bank's per-register write enables and shared write-data bus.

---
 rtl/reg_bank_arbiter.sv | 133 +++++++++++++
 tb/tb_reg_bank_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a DEPTH x WIDTH register bank; sequences each write as
// setup -> enable strobe -> hold. Define ADDR_CHECK_EN to add the Err output and skip the strobe for out-of-range addresses.
module reg_bank_arbiter #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Req0,
   input  logic [AW-1:0]    Addr0,
   input  logic [WIDTH-1:0] Data0,
   input  logic             Req1,
   input  logic [AW-1:0]    Addr1,
   input  logic [WIDTH-1:0] Data1,
   output logic             Gnt0,
   output logic             Gnt1,
   output logic             Ack0,
   output logic             Ack1,
   output logic [DEPTH-1:0] WrEn,
   output logic [WIDTH-1:0] WrData,
   output logic             Busy
`ifdef ADDR_CHECK_EN
   ,
   output logic             Err
`endif
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t             state_q;
   logic               gnt0_q, gnt1_q, ack0_q, ack1_q, busy_q;
   logic [DEPTH-1:0]   wren_q;
   logic [WIDTH-1:0]   wrdata_q;
   logic [AW-1:0]      addr_q;
   logic               win_q;   // requester owning the current transaction
   logic               last_q;  // requester that completed the previous write
`ifdef ADDR_CHECK_EN
   logic               err_q;
`endif

   logic               elig0, elig1, start_d, pick1_d;
   logic [DEPTH-1:0]   dec_d;

   // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
   always_comb begin
      // A requester whose Ack is high is still dropping Req; it must not win again this cycle.
      elig0   = Req0 & ~ack0_q;
      elig1   = Req1 & ~ack1_q;
      start_d = elig0 | elig1;
      pick1_d = elig1 & (~elig0 | ~last_q);
      dec_d   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_q == AW'(i)) dec_d[i] = 1'b1;
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= IDLE;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
         wren_q   <= '0;
         wrdata_q <= '0;
         addr_q   <= '0;
         win_q    <= 1'b0;
         last_q   <= 1'b1;
`ifdef ADDR_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
`ifdef ADDR_CHECK_EN
         err_q  <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start_d) begin
                  win_q    <= pick1_d;
                  gnt0_q   <= ~pick1_d;
                  gnt1_q   <= pick1_d;
                  addr_q   <= pick1_d ? Addr1 : Addr0;
                  wrdata_q <= pick1_d ? Data1 : Data0;
                  busy_q   <= 1'b1;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               // An out-of-range address decodes to all-zero enables.
               wren_q  <= dec_d;
               state_q <= STROBE;
`ifdef ADDR_CHECK_EN
               if (dec_d == '0) state_q <= HOLD;
`endif
            end
            STROBE: begin
               wren_q  <= '0;
               state_q <= HOLD;
            end
            HOLD: begin
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               busy_q  <= 1'b0;
               ack0_q  <= ~win_q;
               ack1_q  <= win_q;
               last_q  <= win_q;
`ifdef ADDR_CHECK_EN
               err_q   <= (dec_d == '0);
`endif
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Gnt0   = gnt0_q;
   assign Gnt1   = gnt1_q;
   assign Ack0   = ack0_q;
   assign Ack1   = ack1_q;
   assign WrEn   = wren_q;
   assign WrData = wrdata_q;
   assign Busy   = busy_q;
`ifdef ADDR_CHECK_EN
   assign Err    = err_q;
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter (DEPTH=3): directed stimulus pushes expected writes,
// a negedge monitor compares each completed transaction and per-cycle invariants.
module tb_reg_bank_arbiter;
   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int AW    = 2;
`ifdef ADDR_CHECK_EN
   localparam bit ACHK = 1'b1;
`else
   localparam bit ACHK = 1'b0;
`endif

   logic             Clk = 1'b0;
   logic             Rst;
   logic             Req0, Req1;
   logic [AW-1:0]    Addr0, Addr1;
   logic [WIDTH-1:0] Data0, Data1;
   logic             Gnt0, Gnt1, Ack0, Ack1, Busy;
   logic [DEPTH-1:0] WrEn;
   logic [WIDTH-1:0] WrData;
`ifdef ADDR_CHECK_EN
   logic             Err;
`endif

   reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .Clk(Clk), .Rst(Rst),
      .Req0(Req0), .Addr0(Addr0), .Data0(Data0),
      .Req1(Req1), .Addr1(Addr1), .Data1(Data1),
      .Gnt0(Gnt0), .Gnt1(Gnt1), .Ack0(Ack0), .Ack1(Ack1),
      .WrEn(WrEn), .WrData(WrData), .Busy(Busy)
`ifdef ADDR_CHECK_EN
      , .Err(Err)
`endif
   );

   initial forever #5 Clk = ~Clk;

   typedef struct {
      int               id;
      logic [DEPTH-1:0] wren;
      logic [WIDTH-1:0] data;
      int               lat;
      logic             err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int id, input logic [DEPTH-1:0] wren, input logic [WIDTH-1:0] data,
                       input int lat, input logic err);
      exp_t e;
      e.id = id; e.wren = wren; e.data = data; e.lat = lat; e.err = err;
      sb.push_back(e);
   endtask

   // sel: 0 Ack0, 1 Ack1, 2 Gnt0, 3 Gnt1, 4 any Gnt, 5 WrEn[2]; returns on the negedge it is seen
   task automatic wait_for(input int sel, input string name);
      bit hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
         @(negedge Clk);
         case (sel)
            0:       hit = Ack0;
            1:       hit = Ack1;
            2:       hit = Gnt0;
            3:       hit = Gnt1;
            4:       hit = Gnt0 | Gnt1;
            default: hit = WrEn[2];
         endcase
      end
      check({"wait_", name}, 32'(hit), 32'd1);
   endtask

   // Monitor: per-cycle invariants plus transaction comparison on each Ack.
   initial begin
      int               busy_cnt, g0_cnt, g1_cnt, wren_pos;
      logic [DEPTH-1:0] wren_acc;
      logic [WIDTH-1:0] first_data;
      logic             data_moved;
      exp_t             e;
      busy_cnt = 0; g0_cnt = 0; g1_cnt = 0; wren_pos = -1; wren_acc = '0; data_moved = 1'b0;
      first_data = '0;
      @(posedge Clk);
      forever begin
         @(negedge Clk);
         check("gnt_exclusive", 32'(Gnt0 & Gnt1), 32'd0);
         check("ack_exclusive", 32'(Ack0 & Ack1), 32'd0);
         check("wren_onehot0", 32'($onehot0(WrEn)), 32'd1);
         check("busy_eq_gnt", 32'(Busy), 32'(Gnt0 | Gnt1));
`ifdef ADDR_CHECK_EN
         check("err_only_with_ack", 32'(Err & ~(Ack0 | Ack1)), 32'd0);
`endif
         if (Ack0 || Ack1) begin
            check("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("ack_id", Ack1 ? 32'd1 : 32'd0, 32'(e.id));
               check("wren_mask", 32'(wren_acc), 32'(e.wren));
               check("wren_cycle", 32'(wren_pos), (e.wren == '0) ? 32'hffff_ffff : 32'd1);
               check("wrdata", 32'(WrData), 32'(e.data));
               check("wrdata_frozen", 32'(data_moved), 32'd0);
               check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
               check("gnt_cycles_own", 32'(e.id == 1 ? g1_cnt : g0_cnt), 32'(e.lat));
               check("gnt_cycles_other", 32'(e.id == 1 ? g0_cnt : g1_cnt), 32'd0);
`ifdef ADDR_CHECK_EN
               check("err", 32'(Err), 32'(e.err));
`endif
            end
            busy_cnt = 0; g0_cnt = 0; g1_cnt = 0; wren_pos = -1; wren_acc = '0; data_moved = 1'b0;
         end else if (Busy) begin
            if (busy_cnt == 0) first_data = WrData;
            else if (WrData !== first_data) data_moved = 1'b1;
            if (WrEn != '0) begin
               wren_acc = wren_acc | WrEn;
               if (wren_pos < 0) wren_pos = busy_cnt;
            end
            g0_cnt += int'(Gnt0);
            g1_cnt += int'(Gnt1);
            busy_cnt++;
         end else begin
            busy_cnt = 0; g0_cnt = 0; g1_cnt = 0; wren_pos = -1; wren_acc = '0; data_moved = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c_a, c_b;
      Rst = 1'b1;
      Req0 = 1'b0; Addr0 = '0; Data0 = '0;
      Req1 = 1'b0; Addr1 = '0; Data1 = '0;
      repeat (2) @(negedge Clk);
      check("rst_gnt0", 32'(Gnt0), 32'd0);
      check("rst_gnt1", 32'(Gnt1), 32'd0);
      check("rst_ack0", 32'(Ack0), 32'd0);
      check("rst_ack1", 32'(Ack1), 32'd0);
      check("rst_wren", 32'(WrEn), 32'd0);
      check("rst_wrdata", 32'(WrData), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
`ifdef ADDR_CHECK_EN
      check("rst_err", 32'(Err), 32'd0);
`endif
      Rst = 1'b0;
      @(negedge Clk);

      // Single write; Req dropped right after grant must not abort it.
      Req0 = 1'b1; Addr0 = 2'd1; Data0 = 8'hA5;
      push(0, 3'b010, 8'hA5, 3, 1'b0);
      wait_for(2, "gnt0_single");
      Req0 = 1'b0;
      wait_for(0, "ack0_single");
      repeat (2) @(negedge Clk);

      // Data/address changes after grant are ignored.
      Req0 = 1'b1; Addr0 = 2'd2; Data0 = 8'h3C;
      push(0, 3'b100, 8'h3C, 3, 1'b0);
      wait_for(2, "gnt0_freeze");
      Data0 = 8'hFF; Addr0 = 2'd0;
      @(negedge Clk);
      Req0 = 1'b0;
      wait_for(0, "ack0_freeze");
      repeat (2) @(negedge Clk);

      // Contention: last winner was 0, so 1 goes first, then alternate every 4 cycles.
      Req0 = 1'b1; Addr0 = 2'd0; Data0 = 8'h11;
      Req1 = 1'b1; Addr1 = 2'd1; Data1 = 8'h22;
      push(1, 3'b010, 8'h22, 3, 1'b0);
      push(0, 3'b001, 8'h11, 3, 1'b0);
      push(1, 3'b010, 8'h22, 3, 1'b0);
      push(0, 3'b001, 8'h11, 3, 1'b0);
      wait_for(1, "ack1_c1"); c_a = cyc;
      wait_for(0, "ack0_c1"); c_b = cyc;
      check("contend_spacing_1", 32'(c_b - c_a), 32'd4);
      wait_for(1, "ack1_c2"); c_a = cyc;
      check("contend_spacing_2", 32'(c_a - c_b), 32'd4);
      wait_for(0, "ack0_c2"); c_b = cyc;
      check("contend_spacing_3", 32'(c_b - c_a), 32'd4);
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (2) @(negedge Clk);

      // Reset while WrEn[2] is high: everything clears, no Ack, pointer back to requester 0.
      Req0 = 1'b1; Addr0 = 2'd2; Data0 = 8'h99;
      wait_for(5, "wren2");
      Rst = 1'b1; Req0 = 1'b0;
      @(negedge Clk);
      check("midrst_wren", 32'(WrEn), 32'd0);
      check("midrst_gnt0", 32'(Gnt0), 32'd0);
      check("midrst_gnt1", 32'(Gnt1), 32'd0);
      check("midrst_busy", 32'(Busy), 32'd0);
      check("midrst_ack0", 32'(Ack0), 32'd0);
      Rst = 1'b0;
      @(negedge Clk);
      check("midrst_no_ack0", 32'(Ack0), 32'd0);
      Req0 = 1'b1; Addr0 = 2'd1; Data0 = 8'h01;
      Req1 = 1'b1; Addr1 = 2'd2; Data1 = 8'h02;
      push(0, 3'b010, 8'h01, 3, 1'b0);
      push(1, 3'b100, 8'h02, 3, 1'b0);
      wait_for(4, "gnt_after_rst");
      check("rst_ptr_gnt0", 32'(Gnt0), 32'd1);
      Req0 = 1'b0;
      wait_for(3, "gnt1_after_rst");
      Req1 = 1'b0;
      wait_for(1, "ack1_after_rst");
      repeat (2) @(negedge Clk);

      // Req1 held through Ack: one write every 5 cycles.
      Req1 = 1'b1; Addr1 = 2'd0; Data1 = 8'h5A;
      push(1, 3'b001, 8'h5A, 3, 1'b0);
      push(1, 3'b001, 8'h5A, 3, 1'b0);
      push(1, 3'b001, 8'h5A, 3, 1'b0);
      wait_for(1, "ack1_h1"); c_a = cyc;
      wait_for(1, "ack1_h2"); c_b = cyc;
      check("held_spacing_1", 32'(c_b - c_a), 32'd5);
      wait_for(1, "ack1_h3"); c_a = cyc;
      check("held_spacing_2", 32'(c_a - c_b), 32'd5);
      Req1 = 1'b0;
      repeat (2) @(negedge Clk);

      // Out-of-range address 3 with DEPTH=3.
      Req1 = 1'b1; Addr1 = 2'd3; Data1 = 8'h77;
      push(1, 3'b000, 8'h77, ACHK ? 2 : 3, ACHK);
      wait_for(3, "gnt1_oor");
      Req1 = 1'b0;
      wait_for(1, "ack1_oor");

      repeat (3) @(negedge Clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
